// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MEM-stage data memory responder.
// Holds the responder FSM encoding and storage geometry helpers.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_e;

    localparam int WORD_BYTES      = 4;
    localparam int DEF_DEPTH_WORDS = 256;

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int DEF_IDX_W = idx_width(DEF_DEPTH_WORDS);

endpackage

// File: rtl/dmem_array.sv
// Word storage for the data memory responder.
// Synchronous write, asynchronous read, contents survive reset.
module dmem_array
    import mips_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int IDX_W       = DEF_IDX_W
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] windex,
    input  logic [31:0]      wdata,
    input  logic [IDX_W-1:0] rindex,
    output logic [31:0]      rdata
);

    logic [31:0] mem_q [DEPTH_WORDS];

    // Word write on the clock edge; no reset so contents persist
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[windex] <= wdata;
        end
    end

    assign rdata = mem_q[rindex];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data memory responder for the MEM-stage load/store port.
// Accepts one request, stalls the pipe for 1+WAIT_CYCLES, flags bad accesses.
module dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        busy,
    output logic        err
);

    localparam int IDX_W = idx_width(DEPTH_WORDS);
    localparam int OFF_W = $clog2(WORD_BYTES);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic        ld_q, ld_d;
    logic        bad_q, bad_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;
    logic        err_q, err_d;

    logic             req;
    logic             addr_bad;
    logic [IDX_W-1:0] in_idx;
    logic             enter_done;
    logic             cur_wr;
    logic             cur_ld;
    logic             cur_bad;
    logic [IDX_W-1:0] cur_idx;
    logic [31:0]      cur_wdata;
    logic             arr_we;
    logic [31:0]      arr_rdata;

    assign req      = MemRead | MemWrite;
    assign addr_bad = (addr[OFF_W-1:0] != '0) ||
                      (addr[31:IDX_W+OFF_W] != '0);
    assign in_idx   = addr[IDX_W+OFF_W-1:OFF_W];

    // Next-state, stall, latching and completion decisions
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        ld_d       = ld_q;
        bad_d      = bad_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        rvalid_d   = 1'b0;
        err_d      = err_q;
        busy       = 1'b0;
        enter_done = 1'b0;
        cur_wr     = wr_q;
        cur_ld     = ld_q;
        cur_bad    = bad_q;
        cur_idx    = idx_q;
        cur_wdata  = wdata_q;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    busy      = 1'b1;
                    wr_d      = MemWrite;
                    ld_d      = MemRead & ~MemWrite;
                    bad_d     = addr_bad;
                    idx_d     = in_idx;
                    wdata_d   = wdata;
                    cnt_d     = WAIT_INIT;
                    err_d     = err_q | addr_bad | (MemRead & MemWrite);
                    cur_wr    = MemWrite;
                    cur_ld    = MemRead & ~MemWrite;
                    cur_bad   = addr_bad;
                    cur_idx   = in_idx;
                    cur_wdata = wdata;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = DONE;
                        enter_done = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                busy  = 1'b1;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d    = DONE;
                    enter_done = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (enter_done && cur_ld) begin
            rvalid_d = 1'b1;
            rdata_d  = cur_bad ? 32'h0 : arr_rdata;
        end
    end

    // A store commits on the edge into DONE unless reset drops it
    assign arr_we = enter_done & cur_wr & ~cur_bad & ~reset;

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            wr_q     <= 1'b0;
            ld_q     <= 1'b0;
            bad_q    <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            ld_q     <= ld_d;
            bad_q    <= bad_d;
            idx_q    <= idx_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .windex(cur_idx),
        .wdata (cur_wdata),
        .rindex(cur_idx),
        .rdata (arr_rdata)
    );

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign err    = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder: two builds (2 and 0 wait states)
// against a word-array reference model with sticky error tracking.
module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam int WC[2] = '{2, 0};

    logic        clk = 1'b0;
    logic        rst [2];
    logic        mr  [2];
    logic        mw  [2];
    logic [31:0] ad  [2];
    logic [31:0] wd  [2];
    logic [31:0] rd  [2];
    logic        rv  [2];
    logic        bs  [2];
    logic        er  [2];

    logic [31:0] mem_m [2][DEPTH];
    logic [31:0] last_rd [2];
    logic        err_m [2];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) u_dut0 (
        .clk(clk), .reset(rst[0]), .MemRead(mr[0]), .MemWrite(mw[0]),
        .addr(ad[0]), .wdata(wd[0]), .rdata(rd[0]), .rvalid(rv[0]),
        .busy(bs[0]), .err(er[0])
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut1 (
        .clk(clk), .reset(rst[1]), .MemRead(mr[1]), .MemWrite(mw[1]),
        .addr(ad[1]), .wdata(wd[1]), .rdata(rd[1]), .rvalid(rv[1]),
        .busy(bs[1]), .err(er[1])
    );

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_in(int s);
        mr[s] = 1'b0;
        mw[s] = 1'b0;
        ad[s] = 32'h0;
        wd[s] = 32'h0;
    endtask

    task automatic noise_in(int s);
        mr[s] = 1'($urandom);
        mw[s] = 1'($urandom);
        ad[s] = $urandom;
        wd[s] = $urandom;
    endtask

    // Entered just after a rising edge with the DUT idle; returns likewise.
    task automatic txn(int s, bit r, bit w, logic [31:0] a, logic [31:0] d);
        bit bad;
        bit ill;
        bit ld;
        int stall;
        logic [31:0] exp_rd;
        bad   = (a[1:0] != 2'b00) || (a >= DEPTH * 4);
        ill   = bad || (r && w);
        ld    = r && !w;
        stall = 1 + WC[s];
        if (ld) exp_rd = bad ? 32'h0 : mem_m[s][a[9:2]];
        else    exp_rd = last_rd[s];
        mr[s] = r;
        mw[s] = w;
        ad[s] = a;
        wd[s] = d;
        for (int c = 0; c <= stall; c++) begin
            @(negedge clk);
            check($sformatf("busy%0d_c%0d", s, c), 32'(bs[s]), 32'(c < stall));
            if (c < stall) begin
                check($sformatf("rvalid%0d_stall", s), 32'(rv[s]), 32'h0);
            end else begin
                check($sformatf("rvalid%0d_done", s), 32'(rv[s]), 32'(ld));
                check($sformatf("rdata%0d", s), rd[s], exp_rd);
                check($sformatf("err%0d", s), 32'(er[s]), 32'(err_m[s] | ill));
            end
            @(posedge clk);
            #1;
            if (c < stall) noise_in(s);
            else           clear_in(s);
        end
        if (w && !bad) mem_m[s][a[9:2]] = d;
        last_rd[s] = exp_rd;
        err_m[s]   = err_m[s] | ill;
    endtask

    task automatic idle(int s, int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check($sformatf("idle_busy%0d", s), 32'(bs[s]), 32'h0);
            check($sformatf("idle_rvalid%0d", s), 32'(rv[s]), 32'h0);
            check($sformatf("idle_err%0d", s), 32'(er[s]), 32'(err_m[s]));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_mid_store(int s, logic [31:0] a, logic [31:0] d);
        mw[s] = 1'b1;
        ad[s] = a;
        wd[s] = d;
        @(negedge clk);
        check("rst_mid_busy_acc", 32'(bs[s]), 32'h1);
        @(posedge clk);
        #1;
        clear_in(s);
        rst[s] = 1'b1;
        @(negedge clk);
        check("rst_mid_busy_wait", 32'(bs[s]), 32'h1);
        @(posedge clk);
        #1;
        rst[s] = 1'b0;
        @(negedge clk);
        check("rst_mid_busy", 32'(bs[s]), 32'h0);
        check("rst_mid_rvalid", 32'(rv[s]), 32'h0);
        check("rst_mid_err", 32'(er[s]), 32'h0);
        check("rst_mid_rdata", rd[s], 32'h0);
        @(posedge clk);
        #1;
        err_m[s]   = 1'b0;
        last_rd[s] = 32'h0;
    endtask

    task automatic rand_txn(int s);
        int kind;
        int op;
        logic [31:0] a;
        kind = $urandom_range(0, 9);
        op   = $urandom_range(0, 9);
        a    = $urandom;
        if (kind == 0)      a = {22'h0, a[9:2], 2'b00} | 32'(1 + $urandom_range(0, 2));
        else if (kind == 1) a = a | 32'h0000_0400;
        else                a = {22'h0, a[9:2], 2'b00};
        if (op == 0)      txn(s, 1'b1, 1'b1, a, $urandom);
        else if (op < 5)  txn(s, 1'b1, 1'b0, a, $urandom);
        else              txn(s, 1'b0, 1'b1, a, $urandom);
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            rst[s]     = 1'b1;
            clear_in(s);
            err_m[s]   = 1'b0;
            last_rd[s] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check("rst_busy", 32'(bs[s]), 32'h0);
            check("rst_rvalid", 32'(rv[s]), 32'h0);
            check("rst_rdata", rd[s], 32'h0);
            check("rst_err", 32'(er[s]), 32'h0);
        end
        @(posedge clk);
        #1;

        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < DEPTH; i++) begin
                txn(s, 1'b0, 1'b1, 32'(i * 4), $urandom);
            end
        end

        txn(0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
        txn(0, 1'b1, 1'b0, 32'h10, 32'h0);
        txn(0, 1'b1, 1'b0, 32'h12, 32'h0);
        idle(0, 10);
        txn(0, 1'b1, 1'b1, 32'h20, 32'h0000_1234);
        txn(0, 1'b1, 1'b0, 32'h20, 32'h0);
        check("both_set_word8", mem_m[0][8], 32'h0000_1234);
        reset_mid_store(0, 32'h30, 32'h55);
        txn(0, 1'b1, 1'b0, 32'h30, 32'h0);
        idle(0, 2);

        txn(1, 1'b0, 1'b1, 32'h40, 32'hCAFE_F00D);
        txn(1, 1'b1, 1'b0, 32'h40, 32'h0);
        txn(1, 1'b1, 1'b0, 32'h400, 32'h0);
        idle(1, 3);

        for (int i = 0; i < 400; i++) begin
            rand_txn(int'($urandom_range(0, 1)));
        end
        idle(0, 2);
        idle(1, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
